// File: rtl/load_store_unit.sv
// Load/store unit with an internal word RAM.
// Stores finish in one cycle; loads stall for two and return data in the third.
module load_store_unit #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] mem [DEPTH];
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        fault_q;

    logic [AW-1:0] idx;
    logic          idle;
    logic          rd_only;
    logic          wr_only;
    logic          aligned;
    logic          f3_ld_ok;
    logic          f3_st_ok;
    logic          legal_ld;
    logic          legal_st;
    logic          illegal;
    logic [3:0]    be;
    logic [31:0]   wr_word;
    logic [31:0]   ld_ext;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          unused_addr;

    // Upper address bits wrap away.
    assign idx         = addr[AW+1:2];
    assign unused_addr = ^addr[31:AW+2];

    assign idle    = (state_q == IDLE);
    assign rd_only = MemRead & ~MemWrite;
    assign wr_only = MemWrite & ~MemRead;

    // Request classification: type, funct3 validity and alignment.
    always_comb begin
        aligned  = 1'b0;
        f3_ld_ok = 1'b0;
        f3_st_ok = 1'b0;
        unique case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        unique case (funct3)
            3'b000, 3'b001, 3'b010: begin
                f3_ld_ok = 1'b1;
                f3_st_ok = 1'b1;
            end
            3'b100, 3'b101: f3_ld_ok = 1'b1;
            default: ;
        endcase
    end

    assign legal_ld = rd_only & f3_ld_ok & aligned;
    assign legal_st = wr_only & f3_st_ok & aligned;
    assign illegal  = (MemRead | MemWrite) & ~legal_ld & ~legal_st;

    // Byte enables and lane-replicated store data.
    always_comb begin
        be      = 4'b0000;
        wr_word = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << addr[1:0];
                wr_word = {4{wdata[7:0]}};
            end
            2'b01: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // Lane extraction and extension of the registered RAM word.
    always_comb begin
        ld_byte = word_q[8*off_q +: 8];
        ld_half = off_q[1] ? word_q[31:16] : word_q[15:0];
        ld_ext  = word_q;
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = word_q;
        endcase
    end

    // RAM write port and synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && idle && legal_st) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
        if (rst_n && idle && legal_ld) begin
            word_q <= mem[idx];
        end
    end

    // Control FSM with registered load data and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (legal_ld) begin
                        state_q <= LOAD;
                        off_q   <= addr[1:0];
                        f3_q    <= funct3;
                    end else if (illegal) begin
                        fault_q <= 1'b1;
                    end
                end
                LOAD: begin
                    rdata_q <= ld_ext;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = rst_n & ((state_q == LOAD) | (idle & legal_ld));
    assign fault     = fault_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases followed by random traffic
// checked against a byte-array memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_out;
    logic        stall;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mb [1024];
    logic [31:0] rd_m;

    load_store_unit #(.DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata_out (rdata_out),
        .stall     (stall),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input bit mr, input bit mw, input logic [2:0] f3,
                                    input logic [31:0] a);
        int n;
        if (mr == mw) return 0;
        if (f3[1:0] == 2'b11) return 0;
        if (mw && f3[2]) return 0;
        if (mr && f3 == 3'b110) return 0;
        n = 1 << f3[1:0];
        return (a % n) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++) v[8*k +: 8] = mb[(a[9:0] + k) % 1024];
        if (!f3[2] && n == 1) v = 32'($signed(v[7:0]));
        if (!f3[2] && n == 2) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    task automatic clear_in();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b000;
        addr     = 32'd0;
        wdata    = 32'd0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        MemWrite = 1'b1;
        funct3   = f3;
        addr     = a;
        wdata    = d;
        #1 chk("st_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 clear_in();
        chk("st_fault", 32'(fault), 32'd0);
        chk("st_rdata", rdata_out, rd_m);
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++) mb[(a[9:0] + k) % 1024] = d[8*k +: 8];
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        MemRead = 1'b1;
        funct3  = f3;
        addr    = a;
        #1 chk("ld_stall_c1", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        MemRead  = 1'($urandom);
        MemWrite = 1'($urandom);
        funct3   = 3'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
        #1 chk("ld_stall_c2", 32'(stall), 32'd1);
        @(posedge clk);
        #1 chk("ld_stall_c3", 32'(stall), 32'd0);
        chk("ld_data", rdata_out, exp);
        rd_m = exp;
        @(posedge clk);
        #1 clear_in();
        chk("ld_hold", rdata_out, rd_m);
    endtask

    task automatic do_illegal(input bit mr, input bit mw, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead  = mr;
        MemWrite = mw;
        funct3   = f3;
        addr     = a;
        wdata    = d;
        #1 chk("ill_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 clear_in();
        chk("ill_fault_on", 32'(fault), 32'd1);
        chk("ill_rdata", rdata_out, rd_m);
        @(posedge clk);
        #1 chk("ill_fault_off", 32'(fault), 32'd0);
    endtask

    task automatic do_idle();
        @(negedge clk);
        clear_in();
        #1 chk("idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 chk("idle_fault", 32'(fault), 32'd0);
    endtask

    initial begin
        bit          mr;
        bit          mw;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;

        rd_m = 32'd0;
        clear_in();
        rst_n   = 1'b0;
        MemRead = 1'b1;
        funct3  = 3'b010;
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("rst_stall_clk", 32'(stall), 32'd0);
        @(negedge clk);
        clear_in();
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) do_store(3'b010, 32'(i * 4), $urandom);

        do_store(3'b010, 32'h10, 32'hDEADBEEF);
        do_load(3'b010, 32'h10, 32'hDEADBEEF);
        do_load(3'b000, 32'h13, 32'hFFFFFFDE);
        do_load(3'b100, 32'h13, 32'h000000DE);
        do_load(3'b001, 32'h12, 32'hFFFFDEAD);
        do_load(3'b101, 32'h10, 32'h0000BEEF);
        do_store(3'b000, 32'h11, 32'h00000055);
        do_load(3'b010, 32'h10, 32'hDEAD55EF);

        do_illegal(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
        do_illegal(1'b0, 1'b1, 3'b001, 32'h11, 32'h12345678);
        do_illegal(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678);
        do_load(3'b010, 32'h10, 32'hDEAD55EF);
        do_load(3'b010, 32'h410, 32'hDEAD55EF);
        do_idle();

        for (int i = 0; i < 400; i++) begin
            mr = 1'($urandom);
            mw = 1'($urandom);
            if ($urandom_range(0, 3) == 0) mw = ~mr;
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d  = $urandom;
            if (!mr && !mw) do_idle();
            else if (!is_legal(mr, mw, f3, a)) do_illegal(mr, mw, f3, a, d);
            else if (mr) do_load(f3, a, ref_load(f3, a));
            else do_store(f3, a, d);
        end

        @(negedge clk);
        MemRead = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h10;
        @(posedge clk);
        #1 chk("abort_in_load", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_rdata", rdata_out, 32'd0);
        rd_m = 32'd0;
        @(negedge clk);
        clear_in();
        rst_n = 1'b1;
        do_idle();
        do_load(3'b010, 32'h10, ref_load(3'b010, 32'h10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use a single clock domain, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-002 Port list:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata_out  out  32  extended load data, drives the Memoria input of the writeback mux
- stall  out  1  core SHALL hold PC and pipeline while high
- fault  out  1  one-cycle pulse on a misaligned, illegal or conflicting request
REQ-003 Parameter: DEPTH, default 256, number of 32-bit words in the internal data RAM.

Function
REQ-004 The block SHALL contain a DEPTH x 32 RAM indexed by addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-005 FSM states SHALL be IDLE, LOAD and DONE.
REQ-006 A request SHALL be legal when exactly one of MemRead/MemWrite is high, funct3 is valid for that request type, and the address is aligned: halfword needs addr[0]=0, word needs addr[1:0]=00.
REQ-007 In IDLE, a legal store SHALL write the RAM at the next rising edge using byte enables:
- SB writes byte addr[1:0] with wdata[7:0]
- SH writes halfword addr[1] with wdata[15:0]
- SW writes all four bytes
stall SHALL stay 0 and the FSM SHALL stay in IDLE.
REQ-008 In IDLE, a legal load SHALL drive stall=1 combinationally in the same cycle, latch addr[1:0] and funct3, and move to LOAD.
REQ-009 In LOAD, stall SHALL be 1; the addressed word SHALL be registered from the RAM, and the FSM SHALL move to DONE.
REQ-010 On entry to DONE, rdata_out SHALL hold the extracted and extended value:
- LB/LH sign-extend
- LBU/LHU zero-extend
- LW passes the word unchanged
- byte lane selected by latched addr[1:0]; halfword lane by latched addr[1]
In DONE, stall SHALL be 0 and the FSM SHALL return to IDLE on the next edge.
REQ-011 Load latency SHALL be exactly two stall cycles; data SHALL be valid in the third cycle of the request.
REQ-012 rdata_out SHALL be registered and SHALL hold its value until the next load reaches DONE; stores and faults SHALL NOT change it.
REQ-013 In IDLE, an illegal request SHALL cause:
- fault=1 for exactly one cycle
- no RAM write
- stall=0
- FSM stays in IDLE
- rdata_out unchanged
REQ-014 MemRead and MemWrite both high SHALL be treated as illegal, and no access SHALL occur.
REQ-015 While the FSM is in LOAD or DONE, changes on MemRead, MemWrite, addr, funct3 and wdata SHALL be ignored.
REQ-016 With no request in IDLE, stall and fault SHALL be 0.

Reset
REQ-017 While rst_n=0, the block SHALL force FSM=IDLE, rdata_out=0, stall=0 and fault=0, regardless of clk.
REQ-018 Reset asserted during LOAD or DONE SHALL abort the load; after release, the FSM SHALL be in IDLE with rdata_out=0.
REQ-019 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-020 SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> stall high 2 cycles, rdata_out=0xDEADBEEF in cycle 3.
REQ-021 After REQ-020, LB addr=0x13 -> rdata_out=0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x10 -> 0x0000BEEF.
REQ-022 SB addr=0x11 wdata=0x00000055, then LW addr=0x10 -> rdata_out=0xDEAD55EF.
REQ-023 LW addr=0x12, SH addr=0x11, and MemRead=MemWrite=1 each -> fault=1 one cycle, stall=0, rdata_out and RAM unchanged.
REQ-024 LW addr=0x410 (DEPTH=256) -> returns word at 0x10; rst_n pulsed low during LOAD -> stall=0 and rdata_out=0 immediately, RAM word at 0x10 retained.
